ws2812_rx_decoder: RTL

- Decodes a WS2812 single-wire pixel stream (the waveform our SPI-to-NeoPixel bridges emit on DO) back into 24-bit GRB pixel words.
- Used as a loopback checker: a bridge's DO pin is fed to DIN, and the words and frame events it produces are compared with the bytes sent over SPI.
- Also serves as a receive front end for boards that chain off another controller.
- Runs on the 50 MHz board clock. All timing parameters are in CLK cycles (20 ns).

---
 rtl/ws2812_rx_decoder_if.sv | 23 ++
 rtl/ws2812_rx_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ws2812_rx_decoder_if.sv
// Pixel-stream bundle between a WS2812 receive decoder and its consumer.
// The decoder side is the master: it samples din and drives the pixel/frame outputs.
interface ws2812_rx_decoder_if #(
  parameter int IDX_W = 3
) ();
  logic             din;
  logic [23:0]      pix_data;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_valid;
  logic             frame_done;
  logic             err;
  logic             busy;

  modport master (
    input  din,
    output pix_data, pix_idx, pix_valid, frame_done, err, busy
  );

  modport slave (
    output din,
    input  pix_data, pix_idx, pix_valid, frame_done, err, busy
  );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// WS2812 single-wire receiver: classifies high-pulse widths into bits, packs
// 24-bit GRB words and reports pixel, latch (frame) and protocol-error events.
module ws2812_rx_decoder #(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_THRESH   = 30,
  parameter int MIN_HIGH     = 5,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  ws2812_rx_decoder_if.master  bus
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CW    = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CW-1:0]    hcnt;
  logic [CW-1:0]    lcnt;
  logic [4:0]       bitcnt;
  logic [15:0]      pixcnt;
  logic [23:0]      sreg;
  logic             pend;
  logic [IDX_W-1:0] pend_idx;
  logic             rise, fall;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here, synchronizer included, is cleared in reset and
      // updated with <= only, so all branches see the same pre-edge values.
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      state          <= SYNC;
      hcnt           <= '0;
      lcnt           <= '0;
      bitcnt         <= '0;
      pixcnt         <= '0;
      sreg           <= '0;
      pend           <= 1'b0;
      pend_idx       <= '0;
      bus.pix_data   <= '0;
      bus.pix_idx    <= '0;
      bus.pix_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      {s3, s2, s1}   <= {s2, s1, bus.din};
      bus.frame_done <= 1'b0;
      bus.err        <= 1'b0;
      bus.pix_valid  <= pend;
      pend           <= 1'b0;
      // Completed pixel is published one cycle after the closing fall.
      if (pend) begin
        bus.pix_data <= sreg;
        bus.pix_idx  <= pend_idx;
      end

      case (state)
        SYNC: begin
          if (s2) begin
            lcnt <= '0;
          end else if (lcnt == CW'(RESET_CYCLES - 1)) begin
            lcnt  <= '0;
            state <= IDLE;
          end else begin
            lcnt <= lcnt + CW'(1);
          end
        end

        IDLE: begin
          bitcnt <= '0;
          pixcnt <= '0;
          if (rise) begin
            hcnt     <= CW'(1);
            bus.busy <= 1'b1;
            state    <= HIGH;
          end
        end

        HIGH: begin
          if (fall) begin
            if (hcnt < CW'(MIN_HIGH)) begin
              // The fall sample is already the first low of the re-sync gap.
              bus.err  <= 1'b1;
              bus.busy <= 1'b0;
              lcnt     <= CW'(1);
              state    <= SYNC;
            end else begin
              sreg  <= {sreg[22:0], (hcnt >= CW'(BIT_THRESH))};
              lcnt  <= CW'(1);
              state <= LOW;
              if (bitcnt == 5'd23) begin
                bitcnt <= '0;
                if (pixcnt < 16'(NUM_LEDS)) begin
                  pend     <= 1'b1;
                  pend_idx <= pixcnt[IDX_W-1:0];
                end else begin
                  bus.err <= 1'b1;
                end
                if (pixcnt != '1) pixcnt <= pixcnt + 16'd1;
              end else begin
                bitcnt <= bitcnt + 5'd1;
              end
            end
          end else if (hcnt == CW'(MAX_HIGH - 1)) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            lcnt     <= '0;
            state    <= SYNC;
          end else begin
            hcnt <= hcnt + CW'(1);
          end
        end

        LOW: begin
          if (rise) begin
            hcnt  <= CW'(1);
            state <= HIGH;
          end else if (lcnt == CW'(RESET_CYCLES - 1)) begin
            if (bitcnt != '0)       bus.err        <= 1'b1;
            else if (pixcnt != '0)  bus.frame_done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            lcnt <= lcnt + CW'(1);
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule
